// File: rtl/pll_rst_seq.sv
// Reset and lock sequencer for the VGA pixel-clock PLL: pulses the PLL reset,
// qualifies lock over a stability window and gates the VGA-domain reset.
module pll_rst_seq #(
  parameter int RST_CYCLES    = 10,
  parameter int LOCK_TIMEOUT  = 5000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_areset,
  output logic       vga_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       error,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q;
  logic             locked_s;
  logic [3:0]       retry_next;

  assign retry_next = retry_cnt + 4'd1;
  assign state_dbg  = state;

  // Two-flop synchronizer; pll_locked is asynchronous to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge,
      // so the chain really is two stages deep regardless of statement order.
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Every output is registered alongside the state so nothing downstream sees
  // a combinational path from pll_locked or restart_req.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= RST_PLL;
      cnt        <= '0;
      pll_areset <= 1'b1;
      vga_rst_n  <= 1'b0;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      error      <= 1'b0;
      retry_cnt  <= 4'd0;
    end else if (restart_req) begin
      state      <= RST_PLL;
      cnt        <= '0;
      pll_areset <= 1'b1;
      vga_rst_n  <= 1'b0;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      error      <= 1'b0;
      retry_cnt  <= 4'd0;
    end else begin
      lock_lost <= 1'b0;
      cnt       <= cnt + 1'b1;
      unique case (state)
        RST_PLL: begin
          if (cnt == RST_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_areset <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_cnt  <= retry_next;
            cnt        <= '0;
            pll_areset <= 1'b1;
            if (retry_next >= RETRY_LIMIT) begin
              state <= FAIL;
              error <= 1'b1;
            end else begin
              state <= RST_PLL;
            end
          end
        end
        STABLE: begin
          // A lock drop wins over completion of the window.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            vga_rst_n <= 1'b1;
            ready     <= 1'b1;
            retry_cnt <= 4'd0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state      <= RST_PLL;
            cnt        <= '0;
            pll_areset <= 1'b1;
            vga_rst_n  <= 1'b0;
            ready      <= 1'b0;
            lock_lost  <= 1'b1;
          end
        end
        FAIL: begin
          // Parked with the PLL held in reset until restart_req or sys_rst_n.
        end
        default: begin
          state      <= RST_PLL;
          cnt        <= '0;
          pll_areset <= 1'b1;
          vga_rst_n  <= 1'b0;
          ready      <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed segment table, async-reset
// corner, then random lock/restart traffic against a timestamp-based model.
module tb_pll_rst_seq;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int STB_C = 8;
  localparam int MAXR  = 2;

  localparam int S_RST  = 0;
  localparam int S_WAIT = 1;
  localparam int S_STB  = 2;
  localparam int S_RUN  = 3;
  localparam int S_FAIL = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_areset, vga_rst_n, ready, lock_lost, error;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  pll_rst_seq #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(STB_C), .MAX_RETRY(MAXR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked),
    .restart_req(restart_req), .pll_areset(pll_areset), .vga_rst_n(vga_rst_n),
    .ready(ready), .lock_lost(lock_lost), .error(error),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  always #10 sys_clk = ~sys_clk;

  // Output vector layout: {state[2:0], areset, vga_rst_n, ready, lock_lost, error, retry[3:0]}
  function automatic logic [11:0] pk(int st, bit ar, bit vg, bit rd, bit ll, bit er, int rt);
    return {3'(st), ar, vg, rd, ll, er, 4'(rt)};
  endfunction

  // Outputs implied by a phase: PLL in reset in RST_PLL/FAIL, released only in RUN.
  function automatic logic [11:0] exp_of(int st, bit ll, int rt);
    return pk(st, (st == S_RST) || (st == S_FAIL), st == S_RUN, st == S_RUN, ll, st == S_FAIL, rt);
  endfunction

  function automatic logic [11:0] dut_vec();
    return {state_dbg, pll_areset, vga_rst_n, ready, lock_lost, error, retry_cnt};
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d ar=%b vg=%b rd=%b ll=%b er=%b rt=%0d, expected st=%0d ar=%b vg=%b rd=%b ll=%b er=%b rt=%0d",
               name, act[11:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp[11:9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reference model: phase plus the edge index it was entered on; elapsed
  // time in a phase is derived from timestamps. Lock is seen two edges late.
  int cyc, entered, m_phase, m_retry;
  bit m_lost;
  bit lock_hist[$];

  function automatic void model_reset();
    cyc = 0; entered = 0; m_phase = S_RST; m_retry = 0; m_lost = 0;
    lock_hist = '{1'b0, 1'b0};
  endfunction

  function automatic void enter(int ph);
    m_phase = ph;
    entered = cyc;
  endfunction

  function automatic void model_step(bit lk, bit rs);
    bit seen;
    int age;
    cyc++;
    age  = cyc - entered - 1;
    seen = lock_hist.pop_front();
    lock_hist.push_back(lk);
    m_lost = 0;
    if (rs) begin
      m_retry = 0;
      enter(S_RST);
    end else if (m_phase == S_RST) begin
      if (age + 1 >= RST_C) enter(S_WAIT);
    end else if (m_phase == S_WAIT) begin
      if (seen) enter(S_STB);
      else if (age + 1 >= TO_C) begin
        m_retry++;
        enter(m_retry >= MAXR ? S_FAIL : S_RST);
      end
    end else if (m_phase == S_STB) begin
      if (!seen) enter(S_WAIT);
      else if (age + 1 >= STB_C) begin
        m_retry = 0;
        enter(S_RUN);
      end
    end else if (m_phase == S_RUN) begin
      if (!seen) begin
        m_lost = 1;
        enter(S_RST);
      end
    end
  endfunction

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic tick(bit lk, bit rs);
    pll_locked  = lk;
    restart_req = rs;
    model_step(lk, rs);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check($sformatf("model@%0d", cyc), dut_vec(), exp_of(m_phase, m_lost, m_retry));
  endtask

  typedef struct {
    int          n;
    bit          lk;
    bit          rs;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit lk;
    bit rs;

    // Segments: apply {lk, rs} for n cycles, then compare against exp.
    tbl.push_back('{3,  1'b0, 1'b0, exp_of(S_RST,  0, 0)});  // power-up: areset held
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_WAIT, 0, 0)});  // exactly 4 cycles of areset
    tbl.push_back('{5,  1'b0, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{2,  1'b1, 1'b0, exp_of(S_WAIT, 0, 0)});  // lock still in synchronizer
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{7,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_RUN,  0, 0)});  // 10 edges after first lock sample
    tbl.push_back('{2,  1'b0, 1'b0, exp_of(S_RUN,  0, 0)});  // lock drop in flight
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_RST,  1, 0)});  // lock_lost pulse
    tbl.push_back('{2,  1'b0, 1'b0, exp_of(S_RST,  0, 0)});  // pulse is single-cycle
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_RST,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{7,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_RUN,  0, 0)});  // relock back to RUN
    tbl.push_back('{1,  1'b1, 1'b1, exp_of(S_RST,  0, 0)});  // restart from RUN: no lock_lost
    tbl.push_back('{3,  1'b1, 1'b0, exp_of(S_RST,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{5,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});  // STABLE cnt=5
    tbl.push_back('{2,  1'b0, 1'b0, exp_of(S_STB,  0, 0)});  // glitch not yet seen
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_WAIT, 0, 0)});  // drop beats completion at cnt=7
    tbl.push_back('{2,  1'b1, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{7,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});  // full window required again
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_RUN,  0, 0)});
    tbl.push_back('{1,  1'b0, 1'b1, exp_of(S_RST,  0, 0)});  // restart, then lock never comes
    tbl.push_back('{3,  1'b0, 1'b0, exp_of(S_RST,  0, 0)});
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{19, 1'b0, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_RST,  0, 1)});  // first timeout
    tbl.push_back('{3,  1'b0, 1'b0, exp_of(S_RST,  0, 1)});
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_WAIT, 0, 1)});
    tbl.push_back('{19, 1'b0, 1'b0, exp_of(S_WAIT, 0, 1)});
    tbl.push_back('{1,  1'b0, 1'b0, exp_of(S_FAIL, 0, 2)});  // second timeout -> FAIL
    tbl.push_back('{30, 1'b0, 1'b0, exp_of(S_FAIL, 0, 2)});  // held indefinitely
    tbl.push_back('{1,  1'b0, 1'b1, exp_of(S_RST,  0, 0)});  // restart clears error/retry
    tbl.push_back('{3,  1'b1, 1'b0, exp_of(S_RST,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_WAIT, 0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{7,  1'b1, 1'b0, exp_of(S_STB,  0, 0)});
    tbl.push_back('{1,  1'b1, 1'b0, exp_of(S_RUN,  0, 0)});

    // Reset state
    model_reset();
    repeat (2) @(negedge sys_clk);
    check("reset_state", dut_vec(), pk(S_RST, 1, 0, 0, 0, 0, 0));
    sys_rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].lk, tbl[i].rs);
      check($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Asynchronous reset mid-cycle while in RUN
    check("run_before_async", dut_vec(), exp_of(S_RUN, 0, 0));
    @(posedge sys_clk);
    #5 sys_rst_n = 1'b0;
    #1 check("async_rst_now", dut_vec(), pk(S_RST, 1, 0, 0, 0, 0, 0));
    model_reset();
    @(negedge sys_clk);
    check("async_rst_held", dut_vec(), pk(S_RST, 1, 0, 0, 0, 0, 0));
    sys_rst_n = 1'b1;

    // Restart landing exactly on the timeout edge must win
    for (int k = 0; k < RST_C + TO_C - 1; k++) tick(1'b0, 1'b0);
    check("pre_timeout", dut_vec(), exp_of(S_WAIT, 0, 0));
    tick(1'b0, 1'b1);
    check("restart_beats_timeout", dut_vec(), exp_of(S_RST, 0, 0));

    // Random lock behaviour with sparse restarts
    lk = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) lk = ~lk;
      rs = ($urandom_range(0, 69) == 0);
      if (lk && $urandom_range(0, 99) == 0) tick(1'b0, rs);
      else tick(lk, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
Reset and lock sequencer for the PLL that generates the VGA pixel clock from the 50 MHz system clock.
- Drives the PLL's active-high reset.
- Qualifies pll_locked over a stability window.
- Releases the VGA-domain reset only once lock is stable.
- Recovers automatically from lock timeout or lock loss, with bounded retries and a sticky fail state.
- Runs entirely on sys_clk and sits between the top-level reset and the pll instance and VGA logic.

Parameters:
RST_CYCLES, 10, cycles pll_areset is held high per reset attempt (>=1)
LOCK_TIMEOUT, 5000, max cycles to wait for lock per attempt (100 us at 50 MHz)
STABLE_CYCLES, 1000, consecutive locked cycles required before release (>=1)
MAX_RETRY, 3, timed-out attempts allowed before FAIL (1..15)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock indicator, asynchronous to sys_clk
restart_req  in  1  synchronous one-cycle pulse forcing a full re-sequence
pll_areset  out  1  active-high reset to PLL
vga_rst_n  out  1  active-low reset for vga_clk-domain logic
ready  out  1  high while in RUN
lock_lost  out  1  one-cycle pulse when lock drops in RUN
error  out  1  high while in FAIL
retry_cnt  out  4  timed-out attempts since last success or restart
state_dbg  out  3  encoded state: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

Behaviour:
- Domain and reset:
  - One clock domain; reset is asynchronous, active-low on sys_rst_n.
  - pll_locked passes through a 2-flop synchronizer; FSM uses only the synchronized value locked_s (2-cycle latency).
- Reset values:
  - state=RST_PLL, cnt=0, sync flops=0.
  - pll_areset=1, vga_rst_n=0, ready=0, lock_lost=0, error=0, retry_cnt=0.
- All outputs are flops updated on the same edge as the state register; no combinational output paths.
- One shared counter cnt: cleared on every state transition, otherwise increments.
  - Width is sufficient for the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- RST_PLL: pll_areset=1, vga_rst_n=0. When cnt==RST_CYCLES-1, go to WAIT_LOCK; pll_areset=0 on that edge.
  - pll_areset is therefore high for exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - locked_s=1: go to STABLE.
  - Else, cnt==LOCK_TIMEOUT-1: retry_cnt+1; if the new value >= MAX_RETRY go to FAIL, else go to RST_PLL.
- STABLE:
  - locked_s=0: return to WAIT_LOCK with cnt cleared; the timeout window restarts and retry_cnt is unchanged.
  - cnt==STABLE_CYCLES-1 with locked_s=1: go to RUN; vga_rst_n=1, ready=1 and retry_cnt=0 on that edge.
- RUN:
  - Holds while locked_s=1.
  - locked_s=0: go to RST_PLL; lock_lost=1 for exactly one cycle; vga_rst_n=0 and ready=0 on the same edge; retry_cnt unchanged.
- FAIL:
  - error=1, pll_areset=1 (PLL held in reset), vga_rst_n=0.
  - Exits only on restart_req or sys_rst_n.
- restart_req (any state, highest synchronous priority):
  - Next state is RST_PLL with cnt=0, retry_cnt=0, error=0.
  - If issued from RUN: lock_lost is NOT asserted; vga_rst_n falls on the same edge.
- Simultaneous events: restart_req beats timeout, lock and unlock events in the same cycle. In STABLE, a lock drop beats stable completion.
- sys_rst_n assertion mid-operation returns all flops to reset values immediately (asynchronously); sequencing restarts from RST_PLL after deassertion.
- Glitches on pll_locked shorter than one sys_clk period may or may not be seen. Any locked_s low during STABLE restarts qualification.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
1. Release sys_rst_n, raise pll_locked at cycle 10 and hold -> pll_areset high cycles 0-3. State_dbg 1 then 2. vga_rst_n and ready rise 10 cycles after the first edge sampling pll_locked=1; retry_cnt=0.
2. Lock never asserted -> two RST_PLL/WAIT_LOCK attempts (pll_areset pulses of 4 cycles) with retry_cnt 1 then 2. Then FAIL: error=1, pll_areset=1, vga_rst_n=0, held indefinitely.
3. In FAIL, pulse restart_req and then give a good lock -> error=0, retry_cnt=0, new 4-cycle pll_areset pulse, RUN reached with ready=1.
4. In RUN, drop pll_locked for 5 cycles -> lock_lost single pulse 3 cycles after the drop, with vga_rst_n=0 and state RST_PLL on that edge. Relock leads back to RUN.
5. Lock glitch low for 3 cycles at STABLE cnt=5 -> returns to WAIT_LOCK, no release. After relock, the full 8-cycle window is required again; retry_cnt unchanged.
6. Assert sys_rst_n low in RUN mid-cycle -> vga_rst_n=0, pll_areset=1, ready=0 immediately (asynchronously). Restart_req in RUN -> vga_rst_n falls and lock_lost stays 0.
